rom_fetch_unit: RTL and testbench
=================================

// Module: rom_fetch_unit
// PURPOSE
//   Read-side sequencer for the 16x12 program ROM. Holds a program counter,
//   drives the ROM address and captures each 12-bit word into an instruction
//   register. Offers the word downstream over a valid/ready handshake.
//   Supports jumps, abort and a programmable end address.
//   Sits between the combinational ROM and the decode/execute stage.
// PARAMETERS
//   ADDR_W      4     ROM address width (PC width)
//   DATA_W      12    ROM word width
//   START_ADDR  0     PC load value on reset, start and abort
//   END_ADDR    15    last address fetched before DONE (sequential path only)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       begin fetching; honoured only in IDLE or DONE
//   abort        in   1       sync abort; any state -> IDLE, drops instr_valid
//   jump_en      in   1       replace PC+1 with jump_addr at handshake
//   jump_addr    in   ADDR_W  jump target
//   rom_addr     out  ADDR_W  registered ROM address, always equals PC
//   rom_data     in   DATA_W  combinational ROM word for rom_addr
//   instr        out  DATA_W  captured instruction word
//   instr_pc     out  ADDR_W  address instr was fetched from
//   instr_valid  out  1       instr/instr_pc are valid
//   instr_ready  in   1       downstream accepts instr this cycle
//   busy         out  1       high in FETCH or VALID
//   done         out  1       high in DONE until start, abort or reset
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, PC=START_ADDR, instr=0, instr_pc=0,
//     instr_valid=0, busy=0, done=0. Outputs settle immediately, no clock.
//   States: IDLE, FETCH, VALID, DONE. Encoding is free.
//   IDLE : start=1 -> PC<=START_ADDR, go to FETCH.
//   FETCH: one cycle. instr<=rom_data, instr_pc<=PC, instr_valid<=1 -> VALID.
//   VALID: hold instr, instr_pc and instr_valid stable while instr_ready=0.
//     On instr_valid&instr_ready:
//     - jump_en=1 -> PC<=jump_addr, go to FETCH. END_ADDR is not checked.
//     - else if PC==END_ADDR -> go to DONE.
//     - else PC<=PC+1 (mod 2^ADDR_W), go to FETCH.
//     In every case instr_valid<=0.
//   DONE : done=1, PC is held. start=1 -> PC<=START_ADDR, go to FETCH.
//   jump_en and jump_addr are sampled only on the handshake cycle.
//   start is ignored in FETCH and VALID.
//   abort has priority over start, the handshake and jump. It sets
//     PC<=START_ADDR and instr_valid<=0 and goes to IDLE. The instr register
//     keeps its value.
//   Latency: start to first instr_valid = 2 cycles. Handshake to next
//     instr_valid = 2 cycles. Peak throughput is 1 word per 2 cycles.
//   Wrap: with END_ADDR=15, PC never wraps on the sequential path. A jump can
//     target any address, including 0 (ROM default word).
//   Reset asserted mid-fetch discards the current word with no handshake.
// TESTING
//   1 Reset: hold rst_n=0 with no clock edge. Expect rom_addr=0,
//     instr_valid=0, busy=0, done=0.
//   2 Sequential, START_ADDR=1, END_ADDR=3, ready tied 1. Expect instr
//     12'h060, 12'hE20, 12'h820 with instr_pc 1,2,3. Then done=1 and busy=0.
//   3 Backpressure: hold ready=0 for 5 cycles at addr 4. Expect instr stable
//     at 12'hC2C and instr_valid=1 throughout. Release ready: next is 5.
//   4 Jump: handshake at addr 2 with jump_en=1, jump_addr=15. Expect next
//     instr=12'hB20, instr_pc=15. Then done asserts (END_ADDR=15).
//   5 Abort while VALID at addr 6. Next cycle expect instr_valid=0, state
//     IDLE, rom_addr=START_ADDR. start then refetches from START_ADDR.
//   6 Async reset pulse in FETCH mid-cycle. Expect outputs at reset values at
//     once, and no instr_valid until a new start.

Source files
------------

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: program-ROM read sequencer. The PC drives the ROM address.
// Each fetched word is latched into an instruction register and offered
// downstream over a valid/ready handshake.
module rom_fetch_unit #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 12,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_PC   = ADDR_W'(END_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              hs;

    assign hs       = instr_valid & instr_ready;
    assign rom_addr = pc;

    // state and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= START_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    // next state / next PC; abort overrides everything else
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (abort) begin
            state_nx = S_IDLE;
            pc_nx    = START_PC;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_nx    = START_PC;
                        state_nx = S_FETCH;
                    end
                end
                S_FETCH: state_nx = S_VALID;
                S_VALID: begin
                    if (hs) begin
                        if (jump_en) begin
                            // jumps bypass the end-address check
                            pc_nx    = jump_addr;
                            state_nx = S_FETCH;
                        end else if (pc == END_PC) begin
                            state_nx = S_DONE;
                        end else begin
                            pc_nx    = pc + ADDR_W'(1);
                            state_nx = S_FETCH;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // status outputs decoded from state
    always_comb begin
        busy = (state == S_FETCH) || (state == S_VALID);
        done = (state == S_DONE);
    end

    // instruction register; abort drops valid but keeps the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (abort) begin
            instr_valid <= 1'b0;
        end else if (state == S_FETCH) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (state == S_VALID && hs) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: scoreboard bench for rom_fetch_unit. Two instances:
// u_seq (START=1, END=3) for the short sequential run, u_dut (defaults)
// for backpressure, jump, abort and reset-in-flight.
module tb_rom_fetch_unit;

    logic        clk, rst_n;
    logic [11:0] rom [16];

    // sequential-run instance
    logic        start_a, abort_a, jen_a, ready_a, valid_a, busy_a, done_a;
    logic [3:0]  jaddr_a, raddr_a, ipc_a;
    logic [11:0] rdata_a, instr_a;

    // main instance
    logic        start_b, abort_b, jen_b, ready_b, valid_b, busy_b, done_b;
    logic [3:0]  jaddr_b, raddr_b, ipc_b;
    logic [11:0] rdata_b, instr_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    assign rdata_a = rom[raddr_a];
    assign rdata_b = rom[raddr_b];

    rom_fetch_unit #(.ADDR_W(4), .DATA_W(12), .START_ADDR(1), .END_ADDR(3)) u_seq (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .jump_en(jen_a), .jump_addr(jaddr_a), .rom_addr(raddr_a),
        .rom_data(rdata_a), .instr(instr_a), .instr_pc(ipc_a),
        .instr_valid(valid_a), .instr_ready(ready_a), .busy(busy_a), .done(done_a)
    );

    rom_fetch_unit #(.ADDR_W(4), .DATA_W(12), .START_ADDR(0), .END_ADDR(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .jump_en(jen_b), .jump_addr(jaddr_b), .rom_addr(raddr_b),
        .rom_data(rdata_b), .instr(instr_b), .instr_pc(ipc_b),
        .instr_valid(valid_b), .instr_ready(ready_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboards: pop on every handshake, compare pc and word
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (q_a.size() == 0) chk("seq_unexpected", 32'(ipc_a), 32'hFFFF);
            else begin
                logic [15:0] e;
                e = q_a.pop_front();
                chk("seq_pc", 32'(ipc_a), 32'(e[15:12]));
                chk("seq_instr", 32'(instr_a), 32'(e[11:0]));
            end
        end
        if (rst_n && valid_b && ready_b) begin
            if (q_b.size() == 0) chk("dut_unexpected", 32'(ipc_b), 32'hFFFF);
            else begin
                logic [15:0] e;
                e = q_b.pop_front();
                chk("dut_pc", 32'(ipc_b), 32'(e[15:12]));
                chk("dut_instr", 32'(instr_b), 32'(e[11:0]));
            end
        end
    end

    task automatic push_b(input logic [3:0] pc);
        q_b.push_back({pc, rom[pc]});
    endtask

    // wait for a valid word on u_dut, then accept it for one cycle
    task automatic accept(input logic [3:0] pc, input logic jmp, input logic [3:0] ja);
        int n = 0;
        while (!valid_b && n < 20) begin
            tick();
            n++;
        end
        if (!valid_b) chk("accept_timeout", 32'(valid_b), 32'd1);
        push_b(pc);
        ready_b = 1'b1;
        jen_b   = jmp;
        jaddr_b = ja;
        tick();
        ready_b = 1'b0;
        jen_b   = 1'b0;
        jaddr_b = '0;
    endtask

    task automatic wait_valid_b();
        int n = 0;
        while (!valid_b && n < 20) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(valid_b), 32'd1);
    endtask

    initial begin
        rom[0]  = 12'h000; rom[1]  = 12'h060; rom[2]  = 12'hE20; rom[3]  = 12'h820;
        rom[4]  = 12'hC2C; rom[5]  = 12'hA11; rom[6]  = 12'h3F0; rom[7]  = 12'h555;
        rom[8]  = 12'h123; rom[9]  = 12'h9AB; rom[10] = 12'h4D2; rom[11] = 12'h777;
        rom[12] = 12'h0F0; rom[13] = 12'hF0F; rom[14] = 12'h246; rom[15] = 12'hB20;
        {start_a, abort_a, jen_a, ready_a, jaddr_a} = '0;
        {start_b, abort_b, jen_b, ready_b, jaddr_b} = '0;
        rst_n = 1'b1;

        // 1: reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_addr", 32'(raddr_b), 32'd0);
        chk("rst_valid", 32'(valid_b), 32'd0);
        chk("rst_busy", 32'(busy_b), 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        chk("rst_addr_seq", 32'(raddr_a), 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 2: sequential run 1..3 with ready tied high
        q_a.push_back({4'd1, 12'h060});
        q_a.push_back({4'd2, 12'hE20});
        q_a.push_back({4'd3, 12'h820});
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("seq_busy", 32'(busy_a), 32'd1);
        tick();
        chk("seq_lat2", 32'(valid_a), 32'd1);
        for (int i = 0; i < 20 && !done_a; i++) tick();
        chk("seq_done", 32'(done_a), 32'd1);
        chk("seq_idle_busy", 32'(busy_a), 32'd0);
        chk("seq_q_empty", 32'(q_a.size()), 32'd0);

        // 3: backpressure at address 4
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int a = 0; a < 4; a++) accept(4'(a), 1'b0, 4'd0);
        wait_valid_b();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(valid_b), 32'd1);
            chk("bp_instr", 32'(instr_b), 32'hC2C);
            chk("bp_pc", 32'(ipc_b), 32'd4);
            tick();
        end
        accept(4'd4, 1'b0, 4'd0);
        accept(4'd5, 1'b0, 4'd0);

        // 5: abort while VALID at address 6
        wait_valid_b();
        chk("ab_pc_before", 32'(ipc_b), 32'd6);
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("ab_valid", 32'(valid_b), 32'd0);
        chk("ab_busy", 32'(busy_b), 32'd0);
        chk("ab_done", 32'(done_b), 32'd0);
        chk("ab_addr", 32'(raddr_b), 32'd0);
        chk("ab_instr_kept", 32'(instr_b), 32'h3F0);
        tick();
        chk("ab_stays_idle", 32'(valid_b), 32'd0);

        // 4: restart, jump from 2 to 15, then done
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        accept(4'd0, 1'b0, 4'd0);
        accept(4'd1, 1'b0, 4'd0);
        accept(4'd2, 1'b1, 4'd15);
        wait_valid_b();
        chk("jmp_instr", 32'(instr_b), 32'hB20);
        chk("jmp_pc", 32'(ipc_b), 32'd15);
        accept(4'd15, 1'b0, 4'd0);
        chk("jmp_done", 32'(done_b), 32'd1);
        chk("jmp_busy", 32'(busy_b), 32'd0);
        chk("jmp_pc_held", 32'(raddr_b), 32'd15);

        // 6: async reset pulse while in FETCH
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("f_busy", 32'(busy_b), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("f_rst_valid", 32'(valid_b), 32'd0);
        chk("f_rst_busy", 32'(busy_b), 32'd0);
        chk("f_rst_done", 32'(done_b), 32'd0);
        chk("f_rst_addr", 32'(raddr_b), 32'd0);
        chk("f_rst_instr", 32'(instr_b), 32'd0);
        chk("f_rst_ipc", 32'(ipc_b), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("f_no_valid", 32'(valid_b), 32'd0);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        accept(4'd0, 1'b0, 4'd0);
        tick();
        chk("dut_q_empty", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
